frame_sequencer: RTL and testbench

// Buffers the continuous audio sample stream and, every HOP new samples, replays the most recent

---
 rtl/frame_sequencer.sv | 171 +++++++++++++++++
 tb/tb_frame_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// frame_sequencer: circular sample buffer that replays the newest FRAME_LEN samples, oldest first,
// every HOP written samples, with window index/first/last markers and a dropped-frame counter. Rev 1.0
module frame_sequencer #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4096,
  parameter int HOP       = 1024
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [WIDTH-1:0]             sample_in,
  input  logic                         sample_valid_in,
  output logic [WIDTH-1:0]             win_sample_out,
  output logic [$clog2(FRAME_LEN)-1:0] win_index_out,
  output logic                         win_valid_out,
  output logic                         win_first_out,
  output logic                         win_last_out,
  input  logic                         win_ready_in,
  output logic                         busy_out,
  output logic                         overrun_out,
  output logic [15:0]                  overrun_count_out
);

  localparam int DEPTH = 2 * FRAME_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = $clog2(FRAME_LEN);
  localparam int FW    = IW + 1;
  localparam int HW    = (HOP > 1) ? $clog2(HOP) : 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [FW-1:0]    r_fill_cnt;
  logic [HW-1:0]    r_hop_cnt;
  state_t           r_state;
  logic [AW-1:0]    r_start;
  logic [IW-1:0]    r_issue_idx;
  logic             r_issue_done;
  logic             r_p1_valid;
  logic [WIDTH-1:0] r_p1_data;
  logic [IW-1:0]    r_p1_idx;
  logic [WIDTH-1:0] r_win_sample;
  logic [IW-1:0]    r_win_index;
  logic             r_win_valid;
  logic             r_win_first;
  logic             r_win_last;
  logic             r_overrun;
  logic [15:0]      r_ovr_cnt;

  logic             w_full;
  logic             w_fill_hit;
  logic             w_hop_last;
  logic             w_trig;
  logic [AW-1:0]    w_wr_next;
  logic [AW-1:0]    w_trig_start;
  logic             w_out_load;
  logic             w_p1_move;
  logic             w_issue;
  logic [AW-1:0]    w_rd_addr;
  logic             w_final_hs;

  assign w_full       = (r_fill_cnt == FW'(FRAME_LEN));
  assign w_fill_hit   = !w_full && (r_fill_cnt == FW'(FRAME_LEN - 1));
  assign w_hop_last   = (r_hop_cnt == HW'(HOP - 1));
  assign w_trig       = sample_valid_in && (w_fill_hit || (w_full && w_hop_last));
  assign w_wr_next    = r_wr_ptr + AW'(1);
  assign w_trig_start = w_wr_next - AW'(FRAME_LEN);

  // Two-stage read path (RAM register, output register); a read is issued only when
  // a slot is guaranteed, so every issued word is delivered exactly once.
  assign w_out_load = !r_win_valid || win_ready_in;
  assign w_p1_move  = r_p1_valid && w_out_load;
  assign w_issue    = (r_state == S_READ) && !r_issue_done && (!r_p1_valid || w_out_load);
  assign w_rd_addr  = r_start + AW'(r_issue_idx);
  assign w_final_hs = r_win_valid && win_ready_in && r_win_last;

  always_ff @(posedge clk_in) begin
    if (sample_valid_in && rst_in) r_mem[r_wr_ptr] <= sample_in;
    if (w_issue) r_p1_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr     <= '0;
      r_fill_cnt   <= '0;
      r_hop_cnt    <= '0;
      r_state      <= S_IDLE;
      r_start      <= '0;
      r_issue_idx  <= '0;
      r_issue_done <= 1'b0;
      r_p1_valid   <= 1'b0;
      r_p1_idx     <= '0;
      r_win_sample <= '0;
      r_win_index  <= '0;
      r_win_valid  <= 1'b0;
      r_win_first  <= 1'b0;
      r_win_last   <= 1'b0;
      r_overrun    <= 1'b0;
      r_ovr_cnt    <= '0;
    end else begin
      r_overrun <= 1'b0;

      if (sample_valid_in) begin
        r_wr_ptr <= w_wr_next;
        if (!w_full) r_fill_cnt <= r_fill_cnt + FW'(1);
        else         r_hop_cnt  <= w_hop_last ? '0 : r_hop_cnt + HW'(1);
      end

      if (w_issue) begin
        r_p1_valid <= 1'b1;
        r_p1_idx   <= r_issue_idx;
      end else if (w_p1_move) begin
        r_p1_valid <= 1'b0;
      end

      if (w_out_load) begin
        r_win_valid <= r_p1_valid;
        if (r_p1_valid) begin
          r_win_sample <= r_p1_data;
          r_win_index  <= r_p1_idx;
          r_win_first  <= (r_p1_idx == '0);
          r_win_last   <= (r_p1_idx == IW'(FRAME_LEN - 1));
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_state      <= S_READ;
            r_start      <= w_trig_start;
            r_issue_idx  <= '0;
            r_issue_done <= 1'b0;
          end
        end
        S_READ: begin
          if (w_issue) begin
            if (r_issue_idx == IW'(FRAME_LEN - 1)) r_issue_done <= 1'b1;
            else                                  r_issue_idx  <= r_issue_idx + IW'(1);
          end
          // A trigger coinciding with the last handshake chains straight into the next frame.
          if (w_final_hs) begin
            if (w_trig) begin
              r_start      <= w_trig_start;
              r_issue_idx  <= '0;
              r_issue_done <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_trig) begin
            r_overrun <= 1'b1;
            if (r_ovr_cnt != 16'hFFFF) r_ovr_cnt <= r_ovr_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign win_sample_out    = r_win_sample;
  assign win_index_out     = r_win_index;
  assign win_valid_out     = r_win_valid;
  assign win_first_out     = r_win_first;
  assign win_last_out      = r_win_last;
  assign busy_out          = (r_state == S_READ);
  assign overrun_out       = r_overrun;
  assign overrun_count_out = r_ovr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// tb_frame_sequencer: directed/randomized bench with a queue-based frame model for frame_sequencer.
// Rev 1.0
module tb_frame_sequencer;
  localparam int W   = 8;
  localparam int F   = 16;
  localparam int HOP = 4;
  localparam int IW  = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [W-1:0]  sample_in;
  logic          sample_valid_in;
  logic [W-1:0]  win_sample_out;
  logic [IW-1:0] win_index_out;
  logic          win_valid_out;
  logic          win_first_out;
  logic          win_last_out;
  logic          win_ready_in;
  logic          busy_out;
  logic          overrun_out;
  logic [15:0]   overrun_count_out;

  frame_sequencer #(.WIDTH(W), .FRAME_LEN(F), .HOP(HOP)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .sample_in         (sample_in),
    .sample_valid_in   (sample_valid_in),
    .win_sample_out    (win_sample_out),
    .win_index_out     (win_index_out),
    .win_valid_out     (win_valid_out),
    .win_first_out     (win_first_out),
    .win_last_out      (win_last_out),
    .win_ready_in      (win_ready_in),
    .busy_out          (busy_out),
    .overrun_out       (overrun_out),
    .overrun_count_out (overrun_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [IW-1:0] idx;
  } exp_t;

  int            n_checks = 0;
  int            n_errors = 0;
  exp_t          exp_q[$];
  logic [W-1:0]  hist[$];
  int            n_wr;
  logic          m_busy;
  logic          exp_pulse;
  logic [15:0]   m_ovr;
  int            obs_pulses;
  logic          prev_stall;
  logic [W+IW+1:0] prev_out;
  logic [W-1:0]  last_frame [F];
  bit            rnd_rdy;
  logic          rdy_fix;
  logic          fin, trig, was_busy, started;
  exp_t          e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: every frame is the last F written samples whenever the write count
  // reaches F or F + k*HOP; a trigger arriving while a frame is still being consumed is dropped.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      exp_q.delete();
      hist.delete();
      n_wr       = 0;
      m_busy     = 1'b0;
      exp_pulse  = 1'b0;
      m_ovr      = '0;
      obs_pulses = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold_stable", 32'({win_sample_out, win_index_out, win_first_out, win_last_out}), 32'(prev_out));
      chk("overrun_pulse", 32'(overrun_out), 32'(exp_pulse));
      chk("overrun_count", 32'(overrun_count_out), 32'(m_ovr));
      chk("busy", 32'(busy_out), 32'(m_busy));
      if (overrun_out) obs_pulses++;

      fin = 1'b0;
      if (win_valid_out && win_ready_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(win_valid_out), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("word_data", 32'(win_sample_out), 32'(e.d));
          chk("word_index", 32'(win_index_out), 32'(e.idx));
          chk("word_first", 32'(win_first_out), 32'(e.idx == 0));
          chk("word_last", 32'(win_last_out), 32'(e.idx == IW'(F - 1)));
          fin = (e.idx == IW'(F - 1));
          last_frame[e.idx] = win_sample_out;
        end
      end

      was_busy  = m_busy && !fin;
      started   = 1'b0;
      exp_pulse = 1'b0;
      if (sample_valid_in) begin
        hist.push_back(sample_in);
        if (hist.size() > F) void'(hist.pop_front());
        n_wr++;
        trig = (n_wr == F) || (n_wr > F && ((n_wr - F) % HOP) == 0);
        if (trig) begin
          if (!was_busy) begin
            for (int i = 0; i < F; i++) begin
              e.d   = hist[i];
              e.idx = IW'(i);
              exp_q.push_back(e);
            end
            started = 1'b1;
          end else begin
            if (m_ovr != 16'hFFFF) m_ovr++;
            exp_pulse = 1'b1;
          end
        end
      end
      m_busy     = started || was_busy;
      prev_stall = win_valid_out && !win_ready_in;
      prev_out   = {win_sample_out, win_index_out, win_first_out, win_last_out};
    end
  end

  task automatic tick(input logic v, input logic [W-1:0] d);
    @(posedge clk_in);
    #1;
    sample_valid_in = v;
    sample_in       = d;
    win_ready_in    = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
  endtask

  task automatic drain();
    int b;
    b = 0;
    repeat (3) tick(1'b0, '0);
    while ((exp_q.size() != 0 || win_valid_out) && b < 400) begin
      tick(1'b0, '0);
      b++;
    end
    chk("drain_within_budget", 32'(b < 400), 32'(1));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_win"}, 32'({win_valid_out, win_sample_out, win_index_out, win_first_out, win_last_out}), 32'(0));
    chk({tag, "_status"}, 32'({busy_out, overrun_out, overrun_count_out}), 32'(0));
  endtask

  initial begin
    rst_in          = 1'b1;
    sample_valid_in = 1'b0;
    sample_in       = '0;
    win_ready_in    = 1'b1;
    rnd_rdy         = 1'b0;
    rdy_fix         = 1'b1;
    #1 rst_in = 1'b0;
    #1 check_reset("reset_initial");
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;

    // Fill and first frame, with first-word latency
    for (int v = 0; v < F; v++) tick(1'b1, W'(v));
    tick(1'b0, '0);
    tick(1'b0, '0);
    chk("latency_not_yet", 32'(win_valid_out), 32'(0));
    tick(1'b0, '0);
    chk("latency_valid", 32'(win_valid_out), 32'(1));
    chk("latency_first_data", 32'(win_sample_out), 32'(0));
    chk("latency_first_flag", 32'(win_first_out), 32'(1));
    drain();
    for (int i = 0; i < F; i++) chk("frame0_content", 32'(last_frame[i]), 32'(i));
    chk("fill_no_overrun", 32'(overrun_count_out), 32'(0));

    // Overlapping frames, one new sample every 8 cycles
    for (int v = F; v < F + 8; v++) begin
      tick(1'b1, W'(v));
      repeat (7) tick(1'b0, '0);
    end
    drain();
    for (int i = 0; i < F; i++) chk("overlap_content", 32'(last_frame[i]), 32'(8 + i));
    chk("overlap_no_overrun", 32'(overrun_count_out), 32'(0));

    // Asynchronous reset in the middle of a replay
    for (int v = 24; v < 28; v++) tick(1'b1, W'(v));
    repeat (5) tick(1'b0, '0);
    chk("midframe_busy", 32'(busy_out), 32'(1));
    #2 rst_in = 1'b0;
    #1 check_reset("reset_midframe");
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;

    // Refill under random backpressure; nothing may come out before the 16th write
    rnd_rdy = 1'b1;
    for (int v = 0; v < F - 1; v++) tick(1'b1, W'(v));
    repeat (6) tick(1'b0, '0);
    chk("no_valid_before_fill", 32'(win_valid_out), 32'(0));
    chk("no_busy_before_fill", 32'(busy_out), 32'(0));
    tick(1'b1, W'(F - 1));
    drain();
    for (int i = 0; i < F; i++) chk("backpressure_content", 32'(last_frame[i]), 32'(i));

    // Overrun: frame held stalled while another hop of samples arrives
    rnd_rdy = 1'b0;
    rdy_fix = 1'b0;
    for (int k = 0; k < HOP; k++) tick(1'b1, W'($urandom));
    repeat (3) tick(1'b0, '0);
    chk("stall_busy", 32'(busy_out), 32'(1));
    chk("stall_valid", 32'(win_valid_out), 32'(1));
    chk("stall_index", 32'(win_index_out), 32'(0));
    for (int k = 0; k < HOP; k++) tick(1'b1, W'($urandom));
    repeat (3) tick(1'b0, '0);
    chk("overrun_count_one", 32'(overrun_count_out), 32'(1));
    chk("overrun_one_pulse", 32'(obs_pulses), 32'(1));
    rdy_fix = 1'b1;
    drain();
    chk("overrun_count_after", 32'(overrun_count_out), 32'(1));

    // Pointer wrap: 40 samples with gaps, last frame must be 24..39
    @(posedge clk_in);
    #3 rst_in = 1'b0;
    #1 check_reset("reset_wrap");
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    for (int v = 0; v < 40; v++) begin
      tick(1'b1, W'(v));
      repeat ($urandom_range(5, 7)) tick(1'b0, '0);
    end
    drain();
    for (int i = 0; i < F; i++) chk("wrap_content", 32'(last_frame[i]), 32'(24 + i));
    chk("wrap_no_overrun", 32'(overrun_count_out), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
